// File: rtl/savestate_bus_master.sv
// Savestate bus initiator: saves a contiguous register index range to memory
// and restores it, ending a restore with a broadcast commit strobe.
module savestate_bus_master #(
    parameter int FIRST_INDEX = 0,
    parameter int REG_COUNT   = 64,
    parameter int RD_LATENCY  = 2,
    parameter int MEM_AW      = 22,
    parameter int MEM_BASE    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_start,
    input  logic              load_start,
    output logic              busy,
    output logic              done,
    output logic [63:0]       SaveStateBus_Din,
    output logic [9:0]        SaveStateBus_Adr,
    output logic              SaveStateBus_wren,
    output logic              SaveStateBus_rst,
    output logic              SaveStateBus_load,
    input  logic [63:0]       SaveStateBus_Dout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(REG_COUNT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        S_ADDR,
        S_WR,
        L_RST,
        L_RD,
        L_WR,
        L_LOAD,
        FIN
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          last_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign last_idx = (idx_q == IDX_LAST);

    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        wait_d            = wait_q;
        wdata_d           = wdata_q;
        rdata_d           = rdata_q;
        done              = 1'b0;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        SaveStateBus_Din  = '0;
        SaveStateBus_wren = 1'b0;
        SaveStateBus_rst  = 1'b0;
        SaveStateBus_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                wait_d = '0;
                if (save_start) begin
                    state_d = S_ADDR;
                end else if (load_start) begin
                    state_d = L_RST;
                end
            end
            S_ADDR: begin
                // Dout is valid on the edge that ends the last wait cycle
                if (wait_q == WAIT_LAST) begin
                    wdata_d = SaveStateBus_Dout;
                    wait_d  = '0;
                    state_d = S_WR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    if (last_idx) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end
            end
            L_RST: begin
                SaveStateBus_rst = 1'b1;
                state_d          = L_RD;
            end
            L_RD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = L_WR;
                end
            end
            L_WR: begin
                SaveStateBus_wren = 1'b1;
                SaveStateBus_Din  = rdata_q;
                if (last_idx) begin
                    state_d = L_LOAD;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = L_RD;
                end
            end
            L_LOAD: begin
                SaveStateBus_load = 1'b1;
                state_d           = FIN;
            end
            FIN: begin
                done    = 1'b1;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // busy already low while the done pulse is out
    assign busy = (state_q != IDLE) && (state_q != FIN);

    assign SaveStateBus_Adr = busy ? (10'(FIRST_INDEX) + 10'(idx_q)) : '0;
    assign mem_addr  = mem_req ? (MEM_AW'(MEM_BASE) + MEM_AW'(idx_q)) : '0;
    assign mem_wdata = wdata_q;

endmodule
